// File: rtl/bcd_bin.sv
// Packed-BCD to binary converter using a sequential reverse double-dabble.
// Ports: clk, rst (sync, active-high), start, bcd_in[4*DIGITS-1:0] ->
//        bin_out[BIN_W-1:0], busy (converting), done (1-cycle strobe),
//        error (last request held a digit > 9).
module bcd_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [BCD_W-1:0]   bcd_work_q;
    logic [BIN_W-1:0]   bin_work_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   bin_out_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;

    logic               digits_ok_d;
    logic [BCD_W-1:0]   bcd_shift_d;
    logic [BCD_W-1:0]   bcd_work_d;
    logic [BIN_W-1:0]   bin_work_d;

    // All digits are checked in parallel at acceptance only.
    always_comb begin
        digits_ok_d = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                digits_ok_d = 1'b0;
            end
        end
    end

    // One reverse double-dabble step. After the right shift, a digit that
    // reads >= 8 received a bit from the digit above worth 5 (10/2) but
    // weighted 8 in binary, so 3 is taken back out.
    always_comb begin
        bcd_shift_d = {1'b0, bcd_work_q[BCD_W-1:1]};
        bin_work_d  = {bcd_work_q[0], bin_work_q[BIN_W-1:1]};
        bcd_work_d  = bcd_shift_d;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_shift_d[4*i +: 4] >= 4'd8) begin
                bcd_work_d[4*i +: 4] = bcd_shift_d[4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bcd_work_q <= '0;
            bin_work_q <= '0;
            cnt_q      <= '0;
            bin_out_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (digits_ok_d) begin
                            bcd_work_q <= bcd_in;
                            bin_work_q <= '0;
                            cnt_q      <= '0;
                            error_q    <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= CONV;
                        end else begin
                            error_q    <= 1'b1;
                            bin_out_q  <= '0;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                CONV: begin
                    bcd_work_q <= bcd_work_d;
                    bin_work_q <= bin_work_d;
                    cnt_q      <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        bin_out_q <= bin_work_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bin_out = bin_out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_bcd_bin.sv
// Self-checking bench for bcd_bin: vector table, corner sequences and an
// exhaustive sweep of all 1000 three-digit inputs.
module tb_bcd_bin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic [9:0]  bin_out;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_bin #(.DIGITS(3), .BIN_W(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        int          bin;
        int          err;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called in the negedge region of an IDLE cycle. Returns in the
    // negedge region of the IDLE cycle following DONE.
    task automatic run(input logic [11:0] v, output int lat,
                       output int bcyc, output int holds_bad);
        logic [9:0] prev;
        lat       = 0;
        bcyc      = 0;
        holds_bad = 0;
        prev      = bin_out;
        start     = 1'b1;
        bcd_in    = v;
        @(posedge clk);
        #1 start = 1'b0;
        bcd_in = 12'hFFF;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) begin
                bcyc++;
                if (bin_out != prev) holds_bad++;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        @(negedge clk);
    endtask

    vec_t vecs[12];
    int lat, bcyc, hb, dn, exp_lat, exp_b;
    string nm;

    initial begin
        vecs[0]  = '{12'h000,   0, 0};
        vecs[1]  = '{12'h999, 999, 0};
        vecs[2]  = '{12'h255, 255, 0};
        vecs[3]  = '{12'h100, 100, 0};
        vecs[4]  = '{12'h1A3,   0, 1};
        vecs[5]  = '{12'h123, 123, 0};
        vecs[6]  = '{12'h001,   1, 0};
        vecs[7]  = '{12'h010,  10, 0};
        vecs[8]  = '{12'h512, 512, 0};
        vecs[9]  = '{12'hF00,   0, 1};
        vecs[10] = '{12'h00A,   0, 1};
        vecs[11] = '{12'h768, 768, 0};

        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bin_out", int'(bin_out), 0);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_done",    int'(done),    0);
        chk("rst_error",   int'(error),   0);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors, issued back-to-back with no idle gap.
        for (int i = 0; i < 12; i++) begin
            run(vecs[i].bcd, lat, bcyc, hb);
            exp_lat = vecs[i].err != 0 ? 1 : 11;
            exp_b   = vecs[i].err != 0 ? 0 : 10;
            nm = $sformatf("%03h", vecs[i].bcd);
            chk({"lat_", nm},   lat,          exp_lat);
            chk({"busy_", nm},  bcyc,         exp_b);
            chk({"hold_", nm},  hb,           0);
            chk({"bin_", nm},   int'(bin_out), vecs[i].bin);
            chk({"err_", nm},   int'(error),   vecs[i].err);
            chk({"dpulse_", nm}, int'(done),   0);
        end

        // Start while busy is ignored; bcd_in changes do not matter.
        start  = 1'b1;
        bcd_in = 12'h042;
        @(posedge clk);
        #1 start = 1'b0;
        dn  = 0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (lat == 0) lat = n;
            end
            start  = (n == 3);
            bcd_in = (n == 3) ? 12'h777 : 12'h555;
        end
        start = 1'b0;
        chk("busy_start_dones", dn,           1);
        chk("busy_start_lat",   lat,          11);
        chk("busy_start_bin",   int'(bin_out), 42);
        chk("busy_start_idle",  int'(busy),   0);

        // Reset mid-conversion aborts without a done pulse.
        start  = 1'b1;
        bcd_in = 12'h999;
        @(posedge clk);
        #1 start = 1'b0;
        dn = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) dn++;
            if (n == 5) chk("abort_busy", int'(busy), 0);
            rst = (n == 4);
        end
        chk("abort_dones", dn,            0);
        chk("abort_bin",   int'(bin_out), 0);
        run(12'h321, lat, bcyc, hb);
        chk("after_abort_lat", lat,           11);
        chk("after_abort_bin", int'(bin_out), 321);

        // Reset wins over a simultaneous start.
        rst    = 1'b1;
        start  = 1'b1;
        bcd_in = 12'h444;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", int'(busy),    0);
        chk("rst_prio_bin",  int'(bin_out), 0);

        // Exhaustive sweep over every valid 3-digit input.
        for (int v = 0; v < 1000; v++) begin
            logic [11:0] b;
            b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            run(b, lat, bcyc, hb);
            chk($sformatf("exh_%0d", v), int'(bin_out), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
